// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the int_ctrl interrupt controller: register offsets,
// mode encodings and small combinational helpers.
package int_ctrl_pkg;

  // Register offsets, equal to CPU address bits [3:2]
  localparam logic [1:0] INTC_REG_MASK = 2'd0;
  localparam logic [1:0] INTC_REG_PEND = 2'd1;
  localparam logic [1:0] INTC_REG_MODE = 2'd2;
  localparam logic [1:0] INTC_REG_TOP  = 2'd3;

  // Per-source latching mode
  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_EDGE  = 1'b1;

  // Bit of the TOP register flagging a valid index
  localparam int TOP_VALID_BIT = 31;

  // Width of the CPU-facing interrupt vector (HWInt[7:2])
  localparam int INTC_MAX_SRC = 6;

  // Mask with the lowest n bits set; bits at or above n belong to no source
  function automatic logic [5:0] src_mask(input int n);
    logic [5:0] m;
    m = 6'b000000;
    for (int i = 0; i < INTC_MAX_SRC; i++) begin
      if (i < n) begin
        m[i] = 1'b1;
      end else begin
        m[i] = 1'b0;
      end
    end
    return m;
  endfunction

  // Lowest set bit of v as an index with the valid flag; all zero when v is empty
  function automatic logic [31:0] top_encode(input logic [5:0] v);
    logic [31:0] r;
    r = 32'h0000_0000;
    for (int i = INTC_MAX_SRC - 1; i >= 0; i--) begin
      if (v[i]) begin
        r                = 32'h0000_0000;
        r[TOP_VALID_BIT] = 1'b1;
        r[2:0]           = 3'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/int_ctrl_src_cell.sv
// One interrupt source: optional input synchronizer, previous-sample flop,
// pending latch with edge/level behaviour, write-1-to-clear and mode-change
// handling. Optional macro: INTC_SYNC_EN adds a 2-flop synchronizer on irq_raw.
module intc_src_cell
  import int_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic irq_raw,
  input  logic mode_cur,
  input  logic mode_we,
  input  logic mode_new,
  input  logic clr,
  output logic pending
);

  logic samp;
  logic prev_q, prev_d;
  logic armed_q, armed_d;
  logic pending_q, pending_d;
  logic rise;
  logic mode_eff;
  logic to_edge;

`ifdef INTC_SYNC_EN
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  // Synchronizer next-state: shift the raw request through two stages
  always_comb begin
    sync1_d = irq_raw;
    sync2_d = sync1_q;
  end

  // Synchronizer flops, cleared on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign samp = sync2_q;
`else
  assign samp = irq_raw;
`endif

  // Next state for prev/armed/pending; set beats a same-cycle W1C clear
  always_comb begin
    prev_d   = samp;
    armed_d  = 1'b1;
    mode_eff = mode_we ? mode_new : mode_cur;
    to_edge  = mode_we && (mode_new == MODE_EDGE) && (mode_cur == MODE_LEVEL);
    // armed_q is low only on the first edge after reset, so a line that is
    // still high across reset is not mistaken for a new edge
    rise     = samp & ~prev_q & armed_q;
    if (to_edge) begin
      pending_d = 1'b0;
    end else if (mode_eff == MODE_EDGE) begin
      pending_d = rise | (pending_q & ~clr);
    end else begin
      pending_d = samp;
    end
  end

  // Source state flops with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q    <= 1'b0;
      armed_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      prev_q    <= prev_d;
      armed_q   <= armed_d;
      pending_q <= pending_d;
    end
  end

  assign pending = pending_q;

endmodule

// File: rtl/int_ctrl.sv
// Memory-mapped interrupt controller feeding CPU HWInt[7:2]. Holds the mask and
// mode registers, the register read mux and the lowest-index priority encoder.
// Optional macro: INTC_SYNC_EN (2-flop input synchronizers in each source cell).
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int         NSRC     = 6,
  parameter logic [5:0] MASK_RST = 6'b000000,
  parameter logic [5:0] MODE_RST = 6'b000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_in,
  input  logic            we,
  input  logic [1:0]      reg_addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic [5:0]      hwint
);

  localparam logic [5:0] SRC_MASK = src_mask(NSRC);

  logic [5:0]  mask_q, mask_d;
  logic [5:0]  mode_q, mode_d;
  logic        mode_we;
  logic [5:0]  clr;
  logic [5:0]  pend;
  logic [31:0] top_val;
  logic        unused_wdata;

  assign unused_wdata = ^wdata[31:6];

  // Register write decode: mask/mode updates and W1C strobes for pending
  always_comb begin
    mask_d  = mask_q;
    mode_d  = mode_q;
    mode_we = 1'b0;
    clr     = 6'b000000;
    if (we) begin
      case (reg_addr)
        INTC_REG_MASK: mask_d = wdata[5:0] & SRC_MASK;
        INTC_REG_PEND: clr    = wdata[5:0] & SRC_MASK;
        INTC_REG_MODE: begin
          mode_d  = wdata[5:0] & SRC_MASK;
          mode_we = 1'b1;
        end
        INTC_REG_TOP:  mode_we = 1'b0;
        default:       mode_we = 1'b0;
      endcase
    end else begin
      mode_we = 1'b0;
    end
  end

  // Mask and mode registers with synchronous reset to their parameter values
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= MASK_RST & SRC_MASK;
      mode_q <= MODE_RST & SRC_MASK;
    end else begin
      mask_q <= mask_d;
      mode_q <= mode_d;
    end
  end

  // One cell per implemented source; missing sources read as never pending
  for (genvar i = 0; i < INTC_MAX_SRC; i++) begin : g_src
    if (i < NSRC) begin : g_cell
      intc_src_cell u_cell (
        .clk      (clk),
        .reset    (reset),
        .irq_raw  (irq_in[i]),
        .mode_cur (mode_q[i]),
        .mode_we  (mode_we),
        .mode_new (mode_d[i]),
        .clr      (clr[i]),
        .pending  (pend[i])
      );
    end else begin : g_tie
      assign pend[i] = 1'b0;
    end
  end

  assign hwint   = pend & mask_q;
  assign top_val = top_encode(hwint);

  // Register read mux, combinational from the current register state
  always_comb begin
    rdata = 32'h0000_0000;
    case (reg_addr)
      INTC_REG_MASK: rdata = {26'd0, mask_q};
      INTC_REG_PEND: rdata = {26'd0, pend};
      INTC_REG_MODE: rdata = {26'd0, mode_q};
      INTC_REG_TOP:  rdata = top_val;
      default:       rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Scoreboard bench for int_ctrl: stimulus pushes expected rdata/hwint pairs,
// a negedge monitor pops and compares them against the DUT.
module tb_int_ctrl;
  import int_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  irq_in;
  logic        we;
  logic [1:0]  reg_addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [5:0]  hwint;

`ifdef INTC_SYNC_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif

  typedef struct {
    string       name;
    logic [31:0] rd;
    logic [5:0]  hw;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  int_ctrl #(.NSRC(6), .MASK_RST(6'h00), .MODE_RST(6'h00)) dut (
    .clk      (clk),
    .reset    (reset),
    .irq_in   (irq_in),
    .we       (we),
    .reg_addr (reg_addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .hwint    (hwint)
  );

  // Monitor: compare queued expectations against the DUT mid-cycle
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks = checks + 1;
      if (rdata !== e.rd) begin
        errors = errors + 1;
        $display("FAIL %s rdata: got %h expected %h", e.name, rdata, e.rd);
      end
      checks = checks + 1;
      if (hwint !== e.hw) begin
        errors = errors + 1;
        $display("FAIL %s hwint: got %b expected %b", e.name, hwint, e.hw);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    reg_addr = a;
    wdata    = d;
    we       = 1'b1;
    tick();
    we       = 1'b0;
    wdata    = 32'h0000_0000;
  endtask

  task automatic rd(input string n, input logic [1:0] a,
                    input logic [31:0] er, input logic [5:0] eh);
    exp_t e;
    reg_addr = a;
    we       = 1'b0;
    e.name   = n;
    e.rd     = er;
    e.hw     = eh;
    exp_q.push_back(e);
    tick();
  endtask

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    irq_in   = 6'b000011;
    we       = 1'b0;
    reg_addr = 2'd0;
    wdata    = 32'h0000_0000;
    tick();
    tick();

    // Reset state
    rd("rst_mask", INTC_REG_MASK, 32'h0000_0000, 6'h00);
    rd("rst_pend", INTC_REG_PEND, 32'h0000_0000, 6'h00);
    rd("rst_mode", INTC_REG_MODE, 32'h0000_0000, 6'h00);
    rd("rst_top",  INTC_REG_TOP,  32'h0000_0000, 6'h00);
    reset = 1'b0;
    tick();
    repeat (EXTRA) tick();
    rd("lvl_after_rst", INTC_REG_PEND, 32'h0000_0003, 6'h00);
    rd("top_unmasked",  INTC_REG_TOP,  32'h0000_0000, 6'h00);

    // Edge capture
    irq_in = 6'b000000;
    wr(INTC_REG_MODE, 32'h0000_003F);
    rd("mode_rb", INTC_REG_MODE, 32'h0000_003F, 6'h00);
    wr(INTC_REG_MASK, 32'h0000_0003);
    irq_in = 6'b000010;
    tick();
    irq_in = 6'b000000;
    repeat (EXTRA) tick();
    rd("edge_pend", INTC_REG_PEND, 32'h0000_0002, 6'h02);
    rd("edge_top",  INTC_REG_TOP,  32'h8000_0001, 6'h02);
    wr(INTC_REG_PEND, 32'h0000_0002);
    rd("w1c_clear", INTC_REG_PEND, 32'h0000_0000, 6'h00);

    // Priority
    irq_in = 6'b000011;
    tick();
    irq_in = 6'b000000;
    repeat (EXTRA) tick();
    rd("prio_both", INTC_REG_TOP, 32'h8000_0000, 6'h03);
    wr(INTC_REG_PEND, 32'h0000_0001);
    rd("prio_bit1", INTC_REG_TOP, 32'h8000_0001, 6'h02);
    wr(INTC_REG_PEND, 32'h0000_0002);
    rd("prio_none", INTC_REG_PEND, 32'h0000_0000, 6'h00);

    // Simultaneous set and clear
    irq_in = 6'b000001;
    tick();
    irq_in = 6'b000000;
    repeat (EXTRA) tick();
    rd("sc_pre", INTC_REG_PEND, 32'h0000_0001, 6'h01);
    irq_in = 6'b000001;
    repeat (EXTRA) tick();
    wr(INTC_REG_PEND, 32'h0000_0001);
    irq_in = 6'b000000;
    rd("sc_set_wins", INTC_REG_PEND, 32'h0000_0001, 6'h01);
    wr(INTC_REG_PEND, 32'h0000_0001);
    rd("sc_clear", INTC_REG_PEND, 32'h0000_0000, 6'h00);

    // Mask gating
    wr(INTC_REG_MASK, 32'h0000_0000);
    irq_in = 6'b000001;
    tick();
    irq_in = 6'b000000;
    repeat (EXTRA) tick();
    rd("mg_pend", INTC_REG_PEND, 32'h0000_0001, 6'h00);
    rd("mg_top",  INTC_REG_TOP,  32'h0000_0000, 6'h00);
    wr(INTC_REG_MASK, 32'h0000_0001);
    rd("mg_unmask", INTC_REG_MASK, 32'h0000_0001, 6'h01);
    rd("mg_top1",   INTC_REG_TOP,  32'h8000_0000, 6'h01);

    // Level mode, upper bits, read-only TOP
    wr(INTC_REG_PEND, 32'h0000_0001);
    wr(INTC_REG_MODE, 32'h0000_0000);
    wr(INTC_REG_MASK, 32'hFFFF_FFFF);
    rd("mask_upper", INTC_REG_MASK, 32'h0000_003F, 6'h00);
    wr(INTC_REG_TOP, 32'hFFFF_FFFF);
    rd("top_ro_mask", INTC_REG_MASK, 32'h0000_003F, 6'h00);
    rd("top_ro_top",  INTC_REG_TOP,  32'h0000_0000, 6'h00);
    rd("lvl_mode",    INTC_REG_MODE, 32'h0000_0000, 6'h00);

    // Level latency: rise then fall
    irq_in = 6'b000100;
    rd("lvl_rise0", INTC_REG_PEND, 32'h0000_0000, 6'h00);
    for (int k = 0; k < EXTRA; k++) rd("lvl_rise_wait", INTC_REG_PEND, 32'h0000_0000, 6'h00);
    rd("lvl_rise", INTC_REG_PEND, 32'h0000_0004, 6'h04);
    irq_in = 6'b000000;
    for (int k = 0; k < EXTRA; k++) rd("lvl_fall_wait", INTC_REG_PEND, 32'h0000_0004, 6'h04);
    rd("lvl_fall_hold", INTC_REG_PEND, 32'h0000_0004, 6'h04);
    rd("lvl_fall",      INTC_REG_PEND, 32'h0000_0000, 6'h00);

    // W1C on a level-mode bit is ignored
    irq_in = 6'b000100;
    repeat (1 + EXTRA) tick();
    wr(INTC_REG_PEND, 32'h0000_0004);
    rd("lvl_w1c_ign", INTC_REG_PEND, 32'h0000_0004, 6'h04);
    irq_in = 6'b000000;
    repeat (2 + EXTRA) tick();
    rd("lvl_idle", INTC_REG_TOP, 32'h0000_0000, 6'h00);

    tick();
    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
